rhs_frame_sequencer: RTL and testbench

RHS_FRAME_SEQUENCER -- requirements
Module: rhs_frame_sequencer

---
 rtl/rhs_seq_pkg.sv | 38 +++
 rtl/rhs_seq_out_fifo.sv | 64 ++++++
 rtl/rhs_frame_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rhs_frame_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhs_seq_pkg.sv
// Shared types and constants for the RHS frame sequencer: FSM states, the default
// header magic, the timestamp length and the output buffer geometry.
package rhs_seq_pkg;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_MAGIC,
      ST_TSTAMP,
      ST_SAMPLES,
      ST_TAIL
   } seq_state_e;

   localparam logic [63:0] MAGIC_DEFAULT  = 64'h8d542c8a49712f0b;
   localparam int unsigned TSTAMP_WORDS   = 2;
   localparam int unsigned OUT_FIFO_DEPTH = 4;
   localparam int unsigned SAMPLE_W       = 16;
   localparam int unsigned STREAM_W       = 3;
   localparam int unsigned CHANNEL_W      = 5;
   localparam int unsigned ENTRY_W        = SAMPLE_W + STREAM_W + CHANNEL_W + 1;

   typedef struct packed {
      logic [SAMPLE_W-1:0]  data;
      logic [STREAM_W-1:0]  stream;
      logic [CHANNEL_W-1:0] channel;
      logic                 last;
   } out_entry_t;

   // Index of the highest enabled stream; 0 when nothing is enabled.
   function automatic logic [STREAM_W-1:0] top_stream(input logic [7:0] mask);
      logic [STREAM_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) idx = STREAM_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rhs_seq_out_fifo.sv
// Four-entry sample buffer with sticky overflow; a push into a full buffer is
// accepted when a pop frees a slot in the same cycle, otherwise it is dropped.
module rhs_seq_out_fifo
   import rhs_seq_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_entry,
   input  logic               i_pop,
   input  logic               i_ovf_clr,
   output logic               o_valid,
   output logic [ENTRY_W-1:0] o_entry,
   output logic               o_overflow
);

   localparam int unsigned PTR_W = $clog2(OUT_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   out_entry_t       r_mem [OUT_FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic w_pop;
   logic w_full;
   logic w_wr;
   logic w_drop;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_full = (r_count == CNT_W'(OUT_FIFO_DEPTH));
   assign w_wr   = i_push && (!w_full || w_pop);
   assign w_drop = i_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < OUT_FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // A fresh drop outranks a clear in the same cycle.
         if (w_drop)         r_overflow <= 1'b1;
         else if (i_ovf_clr) r_overflow <= 1'b0;
      end
   end

   assign o_valid    = (r_count != '0);
   assign o_entry    = r_mem[r_rd_ptr];
   assign o_overflow = r_overflow;

endmodule

// File: rtl/rhs_frame_sequencer.sv
// Frame sequencer: hunts the 64-bit header magic, skips timestamp and tail, and
// forwards samples of enabled streams tagged with stream/channel indices.
// Optional RHS_SEQ_TIMESTAMP_OUT_EN adds a timestamp output port.
module rhs_frame_sequencer
   import rhs_seq_pkg::*;
#(
   parameter logic [63:0] MAGIC        = MAGIC_DEFAULT,
   parameter int unsigned NUM_STREAMS  = 8,
   parameter int unsigned NUM_CHANNELS = 16,
   parameter int unsigned TAIL_WORDS   = 8
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [15:0]            in_data,
   input  logic [NUM_STREAMS-1:0] data_stream_en,
   input  logic                   ovf_clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            out_data,
   output logic [2:0]             out_stream,
   output logic [4:0]             out_channel,
   output logic                   out_last,
   output logic                   frame_start,
   output logic                   in_sync,
`ifdef RHS_SEQ_TIMESTAMP_OUT_EN
   output logic [31:0]            timestamp,
`endif
   output logic                   overflow
);

   localparam int unsigned SAMPLE_WORDS = NUM_CHANNELS * NUM_STREAMS;
   localparam int unsigned CNT_W        = 16;

   seq_state_e             r_state, w_state_nxt;
   logic [1:0]             r_k, w_k_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [NUM_STREAMS-1:0] r_mask, w_mask_nxt;
   logic                   r_in_sync, w_sync_nxt;
   logic                   r_frame_start, w_fs_nxt;
   logic                   r_push, w_push_nxt;
   out_entry_t             r_push_entry, w_entry_nxt;

   logic [15:0]          w_magic_word;
   logic [7:0]           w_mask8;
   logic [STREAM_W-1:0]  w_stream;
   logic [CHANNEL_W-1:0] w_channel;
   logic [STREAM_W-1:0]  w_last_stream;
   logic                 w_enabled;
   logic                 w_is_last;
   out_entry_t           w_head;
   logic                 w_fifo_valid;

   // Sample word i belongs to channel i/NUM_STREAMS, stream i%NUM_STREAMS.
   assign w_magic_word  = MAGIC[{r_k, 4'b0000} +: 16];
   assign w_mask8       = 8'(r_mask);
   assign w_stream      = STREAM_W'(r_cnt % CNT_W'(NUM_STREAMS));
   assign w_channel     = CHANNEL_W'(r_cnt / CNT_W'(NUM_STREAMS));
   assign w_last_stream = top_stream(w_mask8);
   assign w_enabled     = w_mask8[w_stream];
   assign w_is_last     = (w_channel == CHANNEL_W'(NUM_CHANNELS - 1)) &&
                          (w_stream == w_last_stream);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= ST_HUNT;
         r_k           <= '0;
         r_cnt         <= '0;
         r_mask        <= '0;
         r_in_sync     <= 1'b0;
         r_frame_start <= 1'b0;
         r_push        <= 1'b0;
         r_push_entry  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_k           <= w_k_nxt;
         r_cnt         <= w_cnt_nxt;
         r_mask        <= w_mask_nxt;
         r_in_sync     <= w_sync_nxt;
         r_frame_start <= w_fs_nxt;
         r_push        <= w_push_nxt;
         r_push_entry  <= w_entry_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_cnt_nxt   = r_cnt;
      w_mask_nxt  = r_mask;
      w_sync_nxt  = r_in_sync;
      w_fs_nxt    = 1'b0;
      w_push_nxt  = 1'b0;
      w_entry_nxt = r_push_entry;
      if (in_valid) begin
         case (r_state)
            ST_HUNT, ST_MAGIC: begin
               if (in_data == w_magic_word) begin
                  if (r_k == 2'd3) begin
                     w_fs_nxt    = 1'b1;
                     w_sync_nxt  = 1'b1;
                     w_mask_nxt  = data_stream_en;
                     w_state_nxt = ST_TSTAMP;
                     w_k_nxt     = 2'd0;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_k_nxt = r_k + 2'd1;
                  end
               end else begin
                  // Mismatch: a word equal to the first magic word restarts at k=1.
                  w_state_nxt = ST_HUNT;
                  w_sync_nxt  = 1'b0;
                  w_k_nxt     = (in_data == MAGIC[15:0]) ? 2'd1 : 2'd0;
               end
            end
            ST_TSTAMP: begin
               if (r_cnt == CNT_W'(TSTAMP_WORDS - 1)) begin
                  w_state_nxt = ST_SAMPLES;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_SAMPLES: begin
               w_push_nxt  = w_enabled;
               w_entry_nxt = '{data: in_data, stream: w_stream,
                               channel: w_channel, last: w_is_last};
               if (r_cnt == CNT_W'(SAMPLE_WORDS - 1)) begin
                  w_state_nxt = (TAIL_WORDS == 0) ? ST_MAGIC : ST_TAIL;
                  w_k_nxt     = 2'd0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_TAIL: begin
               if (r_cnt == CNT_W'(TAIL_WORDS - 1)) begin
                  w_state_nxt = ST_MAGIC;
                  w_k_nxt     = 2'd0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_HUNT;
               w_k_nxt     = 2'd0;
            end
         endcase
      end
   end

`ifdef RHS_SEQ_TIMESTAMP_OUT_EN
   logic [15:0] r_ts_lo;
   logic [31:0] r_timestamp;

   // Low word is staged so the visible timestamp changes only once per frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ts_lo     <= '0;
         r_timestamp <= '0;
      end else if (in_valid && (r_state == ST_TSTAMP)) begin
         if (r_cnt == '0) r_ts_lo     <= in_data;
         else             r_timestamp <= {in_data, r_ts_lo};
      end
   end

   assign timestamp = r_timestamp;
`endif

   rhs_seq_out_fifo u_out_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (r_push),
      .i_entry    (r_push_entry),
      .i_pop      (out_ready),
      .i_ovf_clr  (ovf_clr),
      .o_valid    (w_fifo_valid),
      .o_entry    (w_head),
      .o_overflow (overflow)
   );

   assign out_valid   = w_fifo_valid;
   assign out_data    = w_head.data;
   assign out_stream  = w_head.stream;
   assign out_channel = w_head.channel;
   assign out_last    = w_head.last;
   assign frame_start = r_frame_start;
   assign in_sync     = r_in_sync;

endmodule

// File: tb/tb_rhs_frame_sequencer.sv
// Scoreboard bench for rhs_frame_sequencer: expected samples are queued as frames
// are driven and a monitor pops them whenever the DUT hands a sample over.
module tb_rhs_frame_sequencer;
   import rhs_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   logic [7:0]  data_stream_en;
   logic        ovf_clr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_stream;
   logic [4:0]  out_channel;
   logic        out_last;
   logic        frame_start;
   logic        in_sync;
   logic        overflow;
`ifdef RHS_SEQ_TIMESTAMP_OUT_EN
   logic [31:0] timestamp;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   int         fs_count = 0;
   int         exp_fs = 0;
   out_entry_t exp_q[$];

   always #5 clk = ~clk;

   rhs_frame_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .data_stream_en (data_stream_en),
      .ovf_clr        (ovf_clr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_stream     (out_stream),
      .out_channel    (out_channel),
      .out_last       (out_last),
      .frame_start    (frame_start),
      .in_sync        (in_sync),
`ifdef RHS_SEQ_TIMESTAMP_OUT_EN
      .timestamp      (timestamp),
`endif
      .overflow       (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted sample is compared with the scoreboard head.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_sample: got %0h expected none",
                     {out_data, out_stream, out_channel, out_last});
         end else begin
            out_entry_t e;
            e = exp_q.pop_front();
            if ({out_data, out_stream, out_channel, out_last} !== e) begin
               n_err++;
               $display("FAIL sample: got %0h expected %0h",
                        {out_data, out_stream, out_channel, out_last}, e);
            end
         end
      end
      if (reset === 1'b1 && frame_start === 1'b1) fs_count++;
   end

   task automatic send_word(input logic [15:0] w);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] magic_word(input int k);
      logic [63:0] m;
      m = MAGIC_DEFAULT;
      return m[16*k +: 16];
   endfunction

   task automatic send_magic(input logic corrupt);
      for (int k = 0; k < 4; k++) begin
         if (corrupt && k == 0) send_word(16'hFFFF);
         else                   send_word(magic_word(k));
      end
   endtask

   // mode 0: data A000+i, mode 1: data cycles through the magic words.
   // cap bounds how many samples are expected; stop_at pulses reset instead of word stop_at.
   task automatic send_body(input logic [7:0] mask, input int mode, input int cap,
                            input int stop_at, input logic chk_lat);
      int         pushed;
      int         hi;
      logic [15:0] d;
      out_entry_t e;
      pushed = 0;
      hi = 0;
      for (int s = 0; s < 8; s++) if (mask[s]) hi = s;
      send_word(16'h1234);
      send_word(16'h5678);
      for (int i = 0; i < 128; i++) begin
         if (i == stop_at) begin
            in_valid = 1'b0;
            reset    = 1'b0;
            @(posedge clk);
            #1;
            exp_q.delete();
            return;
         end
         d = (mode == 1) ? magic_word(i % 4) : 16'hA000 + 16'(i);
         if (mask[i % 8]) begin
            if (pushed < cap) begin
               e.data    = d;
               e.stream  = 3'(i % 8);
               e.channel = 5'(i / 8);
               e.last    = (i / 8 == 15) && (i % 8 == hi);
               exp_q.push_back(e);
            end
            pushed++;
         end
         send_word(d);
         if (chk_lat && i == 0) check("latency_not_yet", 32'(out_valid), 32'd0);
         if (chk_lat && i == 1) check("latency_2", 32'(out_valid), 32'd1);
      end
      for (int t = 0; t < 8; t++) send_word(16'h0000);
   endtask

   task automatic wait_drain(input string name);
      for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      idle(4);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_out_valid"},   32'(out_valid),   32'd0);
      check({tag, "_out_data"},    32'(out_data),    32'd0);
      check({tag, "_out_stream"},  32'(out_stream),  32'd0);
      check({tag, "_out_channel"}, 32'(out_channel), 32'd0);
      check({tag, "_out_last"},    32'(out_last),    32'd0);
      check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      check({tag, "_in_sync"},     32'(in_sync),     32'd0);
      check({tag, "_overflow"},    32'(overflow),    32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] seq_a [5];
      logic [15:0] seq_b [5];
      seq_a = '{16'h000B, 16'h2F0B, 16'h7149, 16'h2C8A, 16'h8D54};
      seq_b = '{16'h2F0B, 16'h2F0B, 16'h4971, 16'h2C8A, 16'h8D54};
      reset = 1'b0; in_valid = 1'b0; in_data = '0;
      data_stream_en = 8'h00; ovf_clr = 1'b0; out_ready = 1'b1;
      idle(2);
      check_reset_vals("reset");
      reset = 1'b1;
      idle(2);

      // Single stream, clean frame.
      data_stream_en = 8'h01;
      send_magic(1'b0); exp_fs++;
      check("frame_start_pulse", 32'(frame_start), 32'd1);
      send_body(8'h01, 0, 999, -1, 1'b1);
      wait_drain("drain_mask01");
      check("fs_count_first", 32'(fs_count), 32'd1);
      check("in_sync_first", 32'(in_sync), 32'd1);
`ifdef RHS_SEQ_TIMESTAMP_OUT_EN
      check("timestamp", timestamp, 32'h5678_1234);
`endif

      // Streams 5 and 7, sample payload made of magic words.
      data_stream_en = 8'hA0;
      send_magic(1'b0); exp_fs++;
      send_body(8'hA0, 1, 999, -1, 1'b0);
      wait_drain("drain_maskA0");
      check("fs_count_no_resync", 32'(fs_count), 32'd2);
      check("in_sync_after_magic_samples", 32'(in_sync), 32'd1);

      // Near-miss header sequences.
      data_stream_en = 8'h01;
      for (int i = 0; i < 5; i++) begin
         send_word(seq_a[i]);
         check("fs_near_miss", 32'(frame_start), 32'd0);
      end
      check("in_sync_lost_near_miss", 32'(in_sync), 32'd0);
      for (int i = 0; i < 4; i++) begin
         send_word(seq_b[i]);
         check("fs_before_last_word", 32'(frame_start), 32'd0);
      end
      send_word(seq_b[4]); exp_fs++;
      check("fs_after_last_word", 32'(frame_start), 32'd1);
      check("in_sync_restart_k1", 32'(in_sync), 32'd1);
      send_body(8'h01, 0, 999, -1, 1'b0);
      wait_drain("drain_restart");

      // Consumer stalled for a whole frame.
      out_ready = 1'b0;
      send_magic(1'b0); exp_fs++;
      send_body(8'h01, 0, 4, -1, 1'b0);
      idle(3);
      check("ovf_set", 32'(overflow), 32'd1);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_channel", 32'(out_channel), 32'd0);
      idle(5);
      check("stall_hold_data", 32'(out_data), 32'h0000_A000);
      out_ready = 1'b1;
      wait_drain("drain_stalled");
      check("ovf_sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      idle(1);
      ovf_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Corrupt header then clean resync.
      send_magic(1'b1);
      check("in_sync_lost", 32'(in_sync), 32'd0);
      send_body(8'h01, 0, 0, -1, 1'b0);
      check("in_sync_still_lost", 32'(in_sync), 32'd0);
      send_magic(1'b0); exp_fs++;
      check("in_sync_regained", 32'(in_sync), 32'd1);
      send_body(8'h01, 0, 999, -1, 1'b0);
      wait_drain("drain_resync");

      // Reset in the middle of the sample block.
      data_stream_en = 8'hFF;
      send_magic(1'b0); exp_fs++;
      send_body(8'hFF, 0, 999, 40, 1'b0);
      check_reset_vals("midreset");
      reset = 1'b1;
      idle(2);
      data_stream_en = 8'h01;
      send_magic(1'b0); exp_fs++;
      send_body(8'h01, 0, 999, -1, 1'b0);
      wait_drain("drain_after_reset");
      check("in_sync_after_reset", 32'(in_sync), 32'd1);
      check("fs_count_total", 32'(fs_count), 32'(exp_fs));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
